// File: rtl/vga_sin_clear_delay.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sin_clear_delay
//  Purpose  : Three independent engines for a 160x120 12-bit VGA frame buffer:
//             a raster screen-clear sweeper, a one-period sine plotter and a
//             programmable cycle-delay timer, each with its own
//             enable / restart / finished handshake.
//  Revision : 1.0  initial release
// ============================================================================
module vga_sin_clear_delay #(
    parameter int          H_PIXELS     = 160,
    parameter int          V_PIXELS     = 120,
    parameter logic [11:0] CLEAR_COLOR  = 12'h000,
    parameter logic [11:0] SIN_COLOR    = 12'h0F0,
    parameter int          SIN_CENTER   = 60,
    parameter int          SIN_AMPL     = 50,
    parameter logic [31:0] DELAY_CYCLES = 32'd1000833
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_enable,
    input  logic        clr_reset,
    output logic [7:0]  clr_x,
    output logic [7:0]  clr_y,
    output logic [11:0] clr_color,
    output logic        clr_finished,
    input  logic        sin_enable,
    input  logic        sin_reset,
    output logic [7:0]  sin_x,
    output logic [7:0]  sin_y,
    output logic [11:0] sin_color,
    output logic        sin_finished,
    input  logic        dly_enable,
    input  logic        dly_reset,
    output logic        dly_finished
);

    localparam logic [7:0] X_LAST    = 8'(H_PIXELS - 1);
    localparam logic [7:0] Y_LAST    = 8'(V_PIXELS - 1);
    localparam logic [7:0] HALF_X    = 8'(H_PIXELS / 2);
    localparam logic [7:0] QUARTER_X = 8'(H_PIXELS / 4);
    localparam logic [7:0] CENTER_Y  = 8'(SIN_CENTER);

    assign clr_color = CLEAR_COLOR;
    assign sin_color = SIN_COLOR;

    // Quarter-wave table round(50*sin(2*pi*i/160)), half away from zero.
    // The peak entry (i=40) is the amplitude itself.
    function automatic logic [6:0] quarter_sine(input logic [5:0] idx);
        case (idx)
            6'd0:  return 7'd0;   6'd1:  return 7'd2;   6'd2:  return 7'd4;
            6'd3:  return 7'd6;   6'd4:  return 7'd8;   6'd5:  return 7'd10;
            6'd6:  return 7'd12;  6'd7:  return 7'd14;  6'd8:  return 7'd15;
            6'd9:  return 7'd17;  6'd10: return 7'd19;  6'd11: return 7'd21;
            6'd12: return 7'd23;  6'd13: return 7'd24;  6'd14: return 7'd26;
            6'd15: return 7'd28;  6'd16: return 7'd29;  6'd17: return 7'd31;
            6'd18: return 7'd32;  6'd19: return 7'd34;  6'd20: return 7'd35;
            6'd21: return 7'd37;  6'd22: return 7'd38;  6'd23: return 7'd39;
            6'd24: return 7'd40;  6'd25: return 7'd42;  6'd26: return 7'd43;
            6'd27: return 7'd44;  6'd28: return 7'd45;  6'd29: return 7'd45;
            6'd30: return 7'd46;  6'd31: return 7'd47;  6'd32: return 7'd48;
            6'd33: return 7'd48;  6'd34: return 7'd49;  6'd35: return 7'd49;
            6'd36: return 7'd49;  6'd37: return 7'd50;  6'd38: return 7'd50;
            6'd39: return 7'd50;
            default: return 7'(SIN_AMPL);
        endcase
    endfunction

    // Clear engine: raster sweep, X fastest, freezes on the last pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_x        <= 8'd0;
            clr_y        <= 8'd0;
            clr_finished <= 1'b0;
        end else if (clr_reset) begin
            clr_x        <= 8'd0;
            clr_y        <= 8'd0;
            clr_finished <= 1'b0;
        end else if (!clr_finished && clr_enable) begin
            if (clr_x == X_LAST && clr_y == Y_LAST) begin
                clr_finished <= 1'b1;
            end else if (clr_x == X_LAST) begin
                clr_x <= 8'd0;
                clr_y <= clr_y + 8'd1;
            end else begin
                clr_x <= clr_x + 8'd1;
            end
        end
    end

    // Sine engine: X steps across the screen once, then freezes at the edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_x        <= 8'd0;
            sin_finished <= 1'b0;
        end else if (sin_reset) begin
            sin_x        <= 8'd0;
            sin_finished <= 1'b0;
        end else if (!sin_finished && sin_enable) begin
            if (sin_x == X_LAST) begin
                sin_finished <= 1'b1;
            end else begin
                sin_x <= sin_x + 8'd1;
            end
        end
    end

    logic       sin_neg;
    logic [7:0] sin_half_pos;
    logic [5:0] sin_idx;
    logic [6:0] sin_mag;

    // Fold X onto the quarter wave and place the sample around the centre row
    always_comb begin
        sin_neg      = (sin_x > HALF_X);
        sin_half_pos = sin_neg ? (sin_x - HALF_X) : sin_x;
        sin_idx      = (sin_half_pos > QUARTER_X) ? 6'(HALF_X - sin_half_pos)
                                                  : 6'(sin_half_pos);
        sin_mag      = quarter_sine(sin_idx);
        sin_y        = sin_neg ? (CENTER_Y + {1'b0, sin_mag})
                               : (CENTER_Y - {1'b0, sin_mag});
    end

    logic [31:0] dly_count;
    logic [31:0] dly_count_next;

    assign dly_count_next = dly_count + 32'd1;

    // Delay engine: count enabled clocks until DELAY_CYCLES is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_count    <= 32'd0;
            dly_finished <= 1'b0;
        end else if (dly_reset) begin
            dly_count    <= 32'd0;
            dly_finished <= 1'b0;
        end else if (!dly_finished && dly_enable) begin
            dly_count <= dly_count_next;
            if (dly_count_next == DELAY_CYCLES) begin
                dly_finished <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sin_clear_delay.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_sin_clear_delay
//  Purpose  : Scoreboard bench for vga_sin_clear_delay: expected pixels are
//             queued as stimulus is driven and popped on every valid pixel.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_sin_clear_delay;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_enable, clr_reset, sin_enable, sin_reset, dly_enable, dly_reset;
    logic [7:0]  clr_x, clr_y, sin_x, sin_y;
    logic [11:0] clr_color, sin_color;
    logic        clr_finished, sin_finished, dly_finished;

    int checks = 0;
    int errors = 0;

    logic [15:0] clr_q[$];
    logic [15:0] sin_q[$];

    vga_sin_clear_delay #(.DELAY_CYCLES(32'd5)) dut (
        .clk(clk), .rst_n(rst_n),
        .clr_enable(clr_enable), .clr_reset(clr_reset),
        .clr_x(clr_x), .clr_y(clr_y), .clr_color(clr_color), .clr_finished(clr_finished),
        .sin_enable(sin_enable), .sin_reset(sin_reset),
        .sin_x(sin_x), .sin_y(sin_y), .sin_color(sin_color), .sin_finished(sin_finished),
        .dly_enable(dly_enable), .dly_reset(dly_reset), .dly_finished(dly_finished)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference sine row: centre minus round-half-away-from-zero sample
    function automatic logic [7:0] sine_row(input int x);
        real v;
        int  s;
        v = 50.0 * $sin(2.0 * 3.14159265358979 * x / 160.0);
        if (v >= 0.0) s = $rtoi(v + 0.5);
        else          s = -$rtoi(-v + 0.5);
        return 8'(60 - s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every valid pixel must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (clr_enable && !clr_finished && !clr_reset) begin
                if (clr_q.size() == 0) check("clr_unexpected_pixel", {clr_x, clr_y}, 32'hFFFF);
                else check("clr_xy", {clr_x, clr_y}, clr_q.pop_front());
                check("clr_color", clr_color, 12'h000);
            end
            if (sin_enable && !sin_finished && !sin_reset) begin
                if (sin_q.size() == 0) check("sin_unexpected_pixel", {sin_x, sin_y}, 32'hFFFF);
                else check("sin_xy", {sin_x, sin_y}, sin_q.pop_front());
                check("sin_color", sin_color, 12'h0F0);
            end
        end
    end

    initial begin
        int k;
        rst_n = 1'b0;
        clr_enable = 0; clr_reset = 0; sin_enable = 0; sin_reset = 0;
        dly_enable = 0; dly_reset = 0;
        repeat (3) tick();
        check("rst_clr_xy", {clr_x, clr_y}, 16'h0);
        check("rst_sin_x", sin_x, 8'd0);
        check("rst_flags", {clr_finished, sin_finished, dly_finished}, 3'b000);
        rst_n = 1'b1;
        tick();

        // Full clear sweep
        clr_reset = 1; tick(); clr_reset = 0;
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                clr_q.push_back({8'(x), 8'(y)});
        clr_enable = 1;
        repeat (19199) tick();
        check("clr_not_done_early", clr_finished, 1'b0);
        tick();
        check("clr_finished", clr_finished, 1'b1);
        repeat (3) tick();
        check("clr_hold_xy", {clr_x, clr_y}, {8'd159, 8'd119});
        check("clr_hold_finished", clr_finished, 1'b1);
        check("clr_queue_drained", clr_q.size(), 0);
        clr_enable = 0;

        // Sine with alternating enable
        sin_reset = 1; tick(); sin_reset = 0;
        for (int x = 0; x < 160; x++) sin_q.push_back({8'(x), sine_row(x)});
        k = 0;
        for (int c = 0; c < 320; c++) begin
            sin_enable = (c % 2 == 0);
            @(negedge clk);
            if (sin_enable) begin
                case (k)
                    0:   check("sin_y_x0",   sin_y, 8'd60);
                    40:  check("sin_y_x40",  sin_y, 8'd10);
                    80:  check("sin_y_x80",  sin_y, 8'd60);
                    120: check("sin_y_x120", sin_y, 8'd110);
                    159: check("sin_y_x159", sin_y, 8'd62);
                    default: ;
                endcase
                if (c == 318) check("sin_not_done_early", sin_finished, 1'b0);
            end
            @(posedge clk); #1;
            if (sin_enable) k++;
        end
        sin_enable = 0;
        check("sin_finished", sin_finished, 1'b1);
        check("sin_hold_x", sin_x, 8'd159);
        check("sin_queue_drained", sin_q.size(), 0);

        // Clear restart mid-sweep at pixel (37,4)
        clr_reset = 1; tick(); clr_reset = 0;
        for (int i = 0; i < 4 * 160 + 37; i++) clr_q.push_back({8'(i % 160), 8'(i / 160)});
        clr_enable = 1;
        repeat (4 * 160 + 37) tick();
        check("clr_at_37_4", {clr_x, clr_y}, {8'd37, 8'd4});
        clr_reset = 1; tick(); clr_reset = 0;
        check("clr_restart_xy", {clr_x, clr_y}, 16'h0);
        for (int i = 0; i < 3; i++) clr_q.push_back({8'(i), 8'd0});
        repeat (3) tick();
        check("clr_restart_no_finish", clr_finished, 1'b0);
        check("clr_restart_queue", clr_q.size(), 0);
        clr_enable = 0;

        // Delay: held enable, then gated
        dly_reset = 1; tick(); dly_reset = 0;
        dly_enable = 1;
        repeat (4) tick();
        check("dly_not_done_4", dly_finished, 1'b0);
        tick();
        check("dly_done_5", dly_finished, 1'b1);
        dly_reset = 1; tick(); dly_reset = 0;
        check("dly_reset_clears", dly_finished, 1'b0);
        repeat (3) tick();
        dly_enable = 0;
        repeat (10) tick();
        check("dly_gated_hold", dly_finished, 1'b0);
        dly_enable = 1;
        tick();
        check("dly_gated_not_done", dly_finished, 1'b0);
        tick();
        check("dly_gated_done", dly_finished, 1'b1);

        // Asynchronous reset mid-operation with every enable high
        sin_reset = 1; tick(); sin_reset = 0;
        clr_q.push_back({8'd3, 8'd0}); clr_q.push_back({8'd4, 8'd0});
        sin_q.push_back({8'd0, sine_row(0)}); sin_q.push_back({8'd1, sine_row(1)});
        clr_enable = 1; sin_enable = 1;
        repeat (2) tick();
        #1 rst_n = 1'b0;
        #1;
        check("async_clr_xy", {clr_x, clr_y}, 16'h0);
        check("async_sin_x", sin_x, 8'd0);
        check("async_flags", {clr_finished, sin_finished, dly_finished}, 3'b000);
        clr_enable = 0; sin_enable = 0; dly_enable = 0;
        #1 rst_n = 1'b1;
        tick();
        check("post_async_xy", {clr_x, clr_y, sin_x}, 24'h0);
        check("post_async_queues", clr_q.size() + sin_q.size(), 0);

        // Delay restart after completion clears on the next edge
        dly_enable = 1;
        repeat (5) tick();
        check("dly_done_again", dly_finished, 1'b1);
        dly_reset = 1; tick(); dly_reset = 0;
        check("dly_reset_after_finish", dly_finished, 1'b0);
        dly_enable = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
